hub75_scan_ctrl: RTL and testbench

Scan scheduler for the HUB75 panel output path. Sequences the fetch/shift engine one (row, bit-plane) at a time and drives the panel control pins: row address, latch and output-enable. Uses binary-code modulation: each plane is shown for a period that doubles per bit. The next plane is shifted in while the current one is displayed.

---
 rtl/hub75_pkg.sv | 24 ++
 rtl/hub75_oe_timer.sv | 71 +++++++
 rtl/hub75_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan scheduler.
package hub75_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StKick,
        StArm,
        StWait,
        StReady,
        StBlank,
        StLatch
    } scan_state_e;

    localparam int unsigned ROW_W  = 6;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned ADDR_W = 5;

    // Wide enough to hold the longest plane period without overflow.
    function automatic int unsigned timer_width(input int unsigned base_cycles,
                                                input int unsigned bits);
        return $clog2(base_cycles << (bits - 1)) + 1;
    endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Display timer: loads the plane period, scales the on-time and generates oe_n/done.
// Brightness scaling is present only when HUB75_GLOBAL_BRIGHTNESS_EN is defined.
module hub75_oe_timer
    import hub75_pkg::*;
#(
    parameter int unsigned BASE_CYCLES = 16,
    parameter int unsigned TW          = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [BIT_W-1:0] load_bit_i,
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    input  logic [7:0]       brightness_i,
`endif
    input  logic             gate_on_i,
    output logic             done_o,
    output logic             oe_n_o
);

    logic [TW-1:0] period;
    logic [TW-1:0] on_cnt;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] off_q, off_d;
    logic          oe_n_q, oe_n_d;

    always_comb period = TW'(BASE_CYCLES) << load_bit_i;

`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    localparam int unsigned PW = TW + 9;
    logic [PW-1:0] scaled;

    always_comb begin
        scaled = PW'(period) * PW'({1'b0, brightness_i} + 9'd1);
        on_cnt = TW'(scaled >> 8);
    end
`else
    always_comb on_cnt = period;
`endif

    // The panel stays lit while the remaining count is above the off threshold,
    // so the tail of the period is dark without changing the pacing.
    always_comb begin
        cnt_d = cnt_q;
        off_d = off_q;
        if (load_i) begin
            cnt_d = period;
            off_d = period - on_cnt;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
        oe_n_d = !(gate_on_i && (cnt_d > off_d));
    end

    // Done one cycle early so READY can leave on the last display cycle.
    assign done_o = (cnt_q <= TW'(1));
    assign oe_n_o = oe_n_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            off_q  <= '0;
            oe_n_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            off_q  <= off_d;
            oe_n_q <= oe_n_d;
        end
    end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan scheduler: shift FSM, row/bit-plane counters and registered panel controls.
// Optional global dimming via HUB75_GLOBAL_BRIGHTNESS_EN.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned SCAN_ROWS    = 32,
    parameter int unsigned BITS         = 8,
    parameter int unsigned BASE_CYCLES  = 16,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              enable,
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    input  logic              busy,
    output logic              start,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic [ROW_W-1:0]  row_cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              lat,
    output logic              oe_n,
    output logic              frame_done
);

    localparam int unsigned TW = timer_width(BASE_CYCLES, BITS);
    localparam int unsigned BW = $clog2(BLANK_CYCLES) + 1;

    localparam logic [BIT_W-1:0] LastBit   = BIT_W'(BITS - 1);
    localparam logic [ROW_W-1:0] LastRow   = ROW_W'(SCAN_ROWS - 1);
    localparam logic [BW-1:0]    BlankLoad = BW'(BLANK_CYCLES - 1);

    scan_state_e       state_q, state_d;
    logic [BW-1:0]     blank_q, blank_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_q, start_d;
    logic              lat_q, lat_d;
    logic              fd_q, fd_d;
    logic              timer_done;
    logic              gate_on;

    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        case (state_q)
            StIdle:  if (enable) state_d = StKick;
            StKick:  state_d = StArm;
            StArm:   state_d = StWait;
            StWait:  if (!busy) state_d = StReady;
            StReady: begin
                if (timer_done) begin
                    state_d = StBlank;
                    blank_d = BlankLoad;
                end
            end
            StBlank: begin
                if (blank_q == '0) state_d = StLatch;
                else               blank_d = blank_q - BW'(1);
            end
            StLatch: state_d = enable ? StKick : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bit 0 first within a row; the row only advances after its last plane.
    always_comb begin
        bit_d = bit_q;
        row_d = row_q;
        if (state_q == StLatch) begin
            if (bit_q == LastBit) begin
                bit_d = '0;
                row_d = (row_q == LastRow) ? '0 : row_q + ROW_W'(1);
            end else begin
                bit_d = bit_q + BIT_W'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        start_d = (state_d == StKick);
        lat_d   = (state_d == StLatch);
        fd_d    = lat_d && (row_q == LastRow) && (bit_q == LastBit);
        addr_d  = lat_d ? row_q[ADDR_W-1:0] : addr_q;
        gate_on = (state_d == StKick) || (state_d == StArm) ||
                  (state_d == StWait) || (state_d == StReady);
    end

    hub75_oe_timer #(
        .BASE_CYCLES (BASE_CYCLES),
        .TW          (TW)
    ) u_oe_timer (
        .clk_i        (sys_clk),
        .rst_ni       (rst_n),
        .load_i       (state_q == StLatch),
        .load_bit_i   (bit_q),
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        .brightness_i (brightness),
`endif
        .gate_on_i    (gate_on),
        .done_o       (timer_done),
        .oe_n_o       (oe_n)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            blank_q <= '0;
            bit_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            start_q <= 1'b0;
            lat_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            bit_q   <= bit_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            lat_q   <= lat_d;
            fd_q    <= fd_d;
        end
    end

    assign start      = start_q;
    assign bit_cnt    = bit_q;
    assign row_cnt    = row_q;
    assign addr       = addr_q;
    assign lat        = lat_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: event-time reference model checked every cycle plus literal pins.
// Define HUB75_GLOBAL_BRIGHTNESS_EN to also exercise global dimming.
module tb_hub75_scan_ctrl;

    localparam int unsigned ROWS  = 2;
    localparam int unsigned NBITS = 3;
    localparam int unsigned BASE  = 4;
    localparam int unsigned BLANK = 2;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b0;
    logic       busy;
    logic       start, lat, oe_n, frame_done;
    logic [2:0] bit_cnt;
    logic [5:0] row_cnt;
    logic [4:0] addr;
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
    logic [7:0] brightness = 8'd255;
`endif

    always #5 sys_clk = ~sys_clk;

    hub75_scan_ctrl #(
        .SCAN_ROWS    (ROWS),
        .BITS         (NBITS),
        .BASE_CYCLES  (BASE),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .enable     (enable),
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .busy       (busy),
        .start      (start),
        .bit_cnt    (bit_cnt),
        .row_cnt    (row_cnt),
        .addr       (addr),
        .lat        (lat),
        .oe_n       (oe_n),
        .frame_done (frame_done)
    );

    // Engine model: busy is high for busy_len cycles starting with the start cycle.
    int busy_len = 5;
    int busy_cnt;
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)              busy_cnt <= 0;
        else if (start)          busy_cnt <= (busy_len > 0) ? busy_len - 1 : 0;
        else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
    end
    assign busy = (busy_len != 0) && (start || busy_cnt != 0);

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference model state: absolute cycle numbers of the next events.
    int k_cyc, l_cyc, lo_s, lo_e, disp_end;
    int m_bit, m_row, m_addr;
    bit m_idle;

    int first_start = -1, first_lat = -1, first_low = -1;
    int lat_cnt = 0, start_cnt = 0, run_len = 0;
    bit rec = 1'b0;
    int widths[$];
    int lat_addr[$];
    int lat_fd[$];
    int lat_cyc[$];

    function automatic int on_count(input int p);
`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        return (p * (int'(brightness) + 1)) >> 8;
`else
        return p;
`endif
    endfunction

    // Kick at k: WAIT is entered at k+2 and left once busy is low; READY then
    // waits for the running display; blanking and the latch follow.
    task automatic schedule_kick(input int k);
        int t, e;
        k_cyc = k;
        t = (k + busy_len > k + 2) ? k + busy_len : k + 2;
        e = (t + 1 > disp_end) ? t + 1 : disp_end;
        l_cyc = e + BLANK + 1;
    endtask

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            cyc = 0; k_cyc = -1; l_cyc = -1; lo_s = 1; lo_e = 0; disp_end = -1000;
            m_bit = 0; m_row = 0; m_addr = 0; m_idle = 1'b1; run_len = 0;
        end else begin : cmp
            bit e_lat, e_start, e_oe_n, e_fd;
            int e_addr, p;
            e_lat   = (cyc == l_cyc);
            e_start = (cyc == k_cyc);
            e_oe_n  = !(cyc >= lo_s && cyc <= lo_e);
            e_addr  = e_lat ? m_row : m_addr;
            e_fd    = e_lat && (m_row == ROWS - 1) && (m_bit == NBITS - 1);
            check("start", int'(start), int'(e_start));
            check("lat", int'(lat), int'(e_lat));
            check("oe_n", int'(oe_n), int'(e_oe_n));
            check("addr", int'(addr), e_addr);
            check("frame_done", int'(frame_done), int'(e_fd));
            check("bit_cnt", int'(bit_cnt), m_bit);
            check("row_cnt", int'(row_cnt), m_row);

            if (start) begin
                start_cnt++;
                if (first_start < 0) first_start = cyc;
            end
            if (lat) begin
                lat_cnt++;
                if (first_lat < 0) first_lat = cyc;
                if (rec) begin
                    lat_addr.push_back(int'(addr));
                    lat_fd.push_back(int'(frame_done));
                    lat_cyc.push_back(cyc);
                end
            end
            if (!oe_n) begin
                run_len++;
                if (first_low < 0) first_low = cyc;
            end else begin
                if (rec && run_len > 0) widths.push_back(run_len);
                run_len = 0;
            end

            if (e_lat) begin
                p = BASE << m_bit;
                m_addr = m_row;
                disp_end = cyc + p;
                if (enable) begin
                    lo_s = cyc + 1;
                    lo_e = cyc + on_count(p);
                end else begin
                    lo_s = 1;
                    lo_e = 0;
                end
                if (m_bit == NBITS - 1) begin
                    m_bit = 0;
                    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
                end else begin
                    m_bit++;
                end
                if (enable) schedule_kick(cyc + 1);
                else begin
                    m_idle = 1'b1; k_cyc = -1; l_cyc = -1;
                end
            end else if (m_idle && enable) begin
                m_idle = 1'b0;
                schedule_kick(cyc + 1);
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    int mark_lat, mark_start, wmax;

    initial begin
        busy_len = 5;
        enable   = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2 rst_n = 1'b1;

        // Drop enable while plane 1 is being shifted.
        step(12);
        enable = 1'b0;
        mark_lat = lat_cnt;
        mark_start = start_cnt;
        step(20);
        check("first_start", first_start, 1);
        check("first_lat", first_lat, 10);
        check("first_oe_low", first_low, 11);
        check("lats_after_drop", lat_cnt - mark_lat, 1);
        check("starts_after_drop", start_cnt - mark_start, 0);
        check("resume_bit", int'(bit_cnt), 2);
        check("idle_oe_n", int'(oe_n), 1);

        // Zero-latency engine, steady state through a frame boundary.
        busy_len = 0;
        widths.delete(); lat_addr.delete(); lat_fd.delete();
        rec = 1'b1;
        enable = 1'b1;
        step(70);
        check("steady_lats", lat_addr.size(), 5);
        if (widths.size() >= 4) begin
            check("width_b2", widths[0], 16);
            check("width_b0", widths[1], 4);
            check("width_b1", widths[2], 8);
            check("width_b2_frame", widths[3], 16);
        end else check("width_count", widths.size(), 4);
        if (lat_addr.size() >= 4) begin
            check("addr_row0", lat_addr[0], 0);
            check("addr_row1", lat_addr[1], 1);
            check("fd_mid", lat_fd[2], 0);
            check("fd_last", lat_fd[3], 1);
        end

        // Engine slower than the display.
        enable = 1'b0;
        step(30);
        busy_len = 30;
        lat_cyc.delete();
        enable = 1'b1;
        step(120);
        if (lat_cyc.size() >= 3) begin
            check("slow_period_a", lat_cyc[1] - lat_cyc[0], 35);
            check("slow_period_b", lat_cyc[2] - lat_cyc[1], 35);
        end else check("slow_lat_count", lat_cyc.size(), 3);

`ifdef HUB75_GLOBAL_BRIGHTNESS_EN
        enable = 1'b0;
        step(60);
        busy_len = 0;
        brightness = 8'd127;
        widths.delete();
        enable = 1'b1;
        step(90);
        if (widths.size() >= 3) begin
            check("dim_b0", widths[0], 2);
            check("dim_b1", widths[1], 4);
            check("dim_b2", widths[2], 8);
        end else check("dim_count", widths.size(), 3);
        wmax = 0;
        foreach (widths[i]) if (widths[i] > wmax) wmax = widths[i];
        check("dim_max", wmax, 8);
        enable = 1'b0;
        step(60);
        brightness = 8'd0;
        widths.delete();
        enable = 1'b1;
        step(60);
        check("dark_widths", widths.size(), 0);
`endif

        // Asynchronous reset in the middle of scanning.
        enable = 1'b1;
        step(7);
        rst_n = 1'b0;
        #1;
        check("rst_start", int'(start), 0);
        check("rst_lat", int'(lat), 0);
        check("rst_oe_n", int'(oe_n), 1);
        check("rst_bit", int'(bit_cnt), 0);
        check("rst_row", int'(row_cnt), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_fd", int'(frame_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
